// File: rtl/gen_pulsos_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulsos_pkg
// Description : Shared state type and default widths for the pulse generator.
// Revision    : 1.0 - initial release
// ============================================================================
package pulsos_pkg;

  localparam int GEN_CNT_W  = 8;
  localparam int GEN_TIME_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } gen_state_t;

endpackage
`default_nettype wire

// File: rtl/gen_pulsos_if.sv
`default_nettype none
// ============================================================================
// Module      : gen_pulsos_if
// Description : Start/parameter request and pulse-train status bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface gen_pulsos_if
  import pulsos_pkg::*;
#(
  parameter int CNT_W  = GEN_CNT_W,
  parameter int TIME_W = GEN_TIME_W
);

  logic              start_i;
  logic [CNT_W-1:0]  n_pulses_i;
  logic [TIME_W-1:0] high_i;
  logic [TIME_W-1:0] low_i;
  logic              pulse_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    output start_i, n_pulses_i, high_i, low_i,
    input  pulse_o, busy_o, done_o
  );

  modport slave (
    input  start_i, n_pulses_i, high_i, low_i,
    output pulse_o, busy_o, done_o
  );

endinterface
`default_nettype wire

// File: rtl/gen_pulsos_contador_fase.sv
`default_nettype none
// ============================================================================
// Module      : contador_fase
// Description : Loadable phase down counter; a zero load is clamped to one.
// Revision    : 1.0 - initial release
// ============================================================================
module contador_fase
  import pulsos_pkg::*;
#(
  parameter int TIME_W = GEN_TIME_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [TIME_W-1:0] value_i,
  output logic              end_o
);

  localparam logic [TIME_W-1:0] c_one = TIME_W'(1);

  logic [TIME_W-1:0] r_cnt;
  logic [TIME_W-1:0] w_load_val;

  always_comb begin
    w_load_val = (value_i == '0) ? c_one : value_i;
  end

  // Counts down to zero and parks there, so it never wraps between phases.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= w_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - c_one;
    end
  end

  assign end_o = (r_cnt == c_one);

endmodule
`default_nettype wire

// File: rtl/gen_pulsos.sv
`default_nettype none
// ============================================================================
// Module      : gen_pulsos
// Description : Programmable pulse-train generator with completion strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module gen_pulsos
  import pulsos_pkg::*;
#(
  parameter int CNT_W  = GEN_CNT_W,
  parameter int TIME_W = GEN_TIME_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  gen_pulsos_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  gen_state_t        r_state;
  logic [CNT_W-1:0]  r_remaining;
  logic [TIME_W-1:0] r_high;
  logic [TIME_W-1:0] r_low;
  logic              r_pulse;
  logic              r_busy;
  logic              r_done;

  logic              w_load;
  logic [TIME_W-1:0] w_load_val;
  logic              w_phase_end;

  // Phase-counter reload; IDLE loads straight from the bus since the latch
  // of high_i happens on the same edge.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = r_high;
    case (r_state)
      IDLE: begin
        if (bus.start_i && (bus.n_pulses_i != '0)) begin
          w_load     = 1'b1;
          w_load_val = bus.high_i;
        end
      end
      HIGH: begin
        if (w_phase_end && (r_remaining != c_cnt_one)) begin
          w_load     = 1'b1;
          w_load_val = r_low;
        end
      end
      LOW: begin
        if (w_phase_end) begin
          w_load     = 1'b1;
          w_load_val = r_high;
        end
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  contador_fase #(
    .TIME_W (TIME_W)
  ) u_contador_fase (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (w_load),
    .value_i (w_load_val),
    .end_o   (w_phase_end)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_high      <= '0;
      r_low       <= '0;
      r_pulse     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pulse <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          if (bus.start_i) begin
            r_high      <= bus.high_i;
            r_low       <= bus.low_i;
            r_remaining <= bus.n_pulses_i;
            if (bus.n_pulses_i == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= HIGH;
              r_pulse <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (w_phase_end) begin
            r_remaining <= r_remaining - c_cnt_one;
            r_pulse     <= 1'b0;
            if (r_remaining == c_cnt_one) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= LOW;
            end
          end
        end
        LOW: begin
          if (w_phase_end) begin
            r_state <= HIGH;
            r_pulse <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_pulse <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pulse_o = r_pulse;
  assign bus.busy_o  = r_busy;
  assign bus.done_o  = r_done;

endmodule
`default_nettype wire

// File: doc/gen_pulsos.md
# gen_pulsos

Pulse-train generator: the transmitting counterpart of the button-to-pulse path. On a one-cycle start request it emits a programmable number of pulses on `pulse_o`, with programmable high and low widths in clock cycles. It then signals completion. It sits beside the existing pulse-detection FSM and drives LEDs or test stimulus from internal single-cycle events (for example, the detector's `pulse_o`).

## Interface
Parameters:
- `CNT_W`, 8: width of the pulse-count input.
- `TIME_W`, 16: width of the high/low duration inputs.

Ports:
- `clk_i`  input  1  single clock; all logic on its rising edge.
- `rst_i`  input  1  reset, asynchronous, active-high.
- `start_i`  input  1  start request, synchronous, sampled only in IDLE.
- `n_pulses_i`  input  CNT_W  number of pulses to emit; sampled with start.
- `high_i`  input  TIME_W  high width in cycles; sampled with start.
- `low_i`  input  TIME_W  gap between pulses in cycles; sampled with start.
- `pulse_o`  output  1  pulse train, registered.
- `busy_o`  output  1  high while a train is in progress (HIGH or LOW state).
- `done_o`  output  1  single-cycle completion strobe.

## Operation
- FSM states are IDLE, HIGH, LOW and DONE. Reset state is IDLE.
- Reset values: `pulse_o`=0, `busy_o`=0, `done_o`=0. All internal counters are 0.
- **IDLE**
  - If `start_i`=1, latch `n_pulses_i`, `high_i` and `low_i`.
  - If the latched N=0, go to DONE; no pulse is emitted.
  - Otherwise go to HIGH, load the phase counter with H, and load the remaining-pulse counter with N.
- **HIGH**
  - `pulse_o`=1 for exactly H cycles.
  - At the end of the phase, decrement the remaining count.
  - If the count is now 0, go to DONE. Otherwise go to LOW with the phase counter loaded with L.
- **LOW**
  - `pulse_o`=0 for exactly L cycles, then go to HIGH with the phase counter loaded with H.
- **DONE**
  - `done_o`=1 and `pulse_o`=0 for one cycle, then go to IDLE.
- Width clamp: a latched `high_i` or `low_i` of 0 is treated as 1. The effective H and L are always at least 1.
- `start_i` is ignored in HIGH, LOW and DONE. Retrigger is not queued.
- Input changes after the start cycle have no effect on the current train, because the parameters are latched.
- The phase counter is TIME_W wide and the pulse counter is CNT_W wide. Neither counter wraps: each counter is loaded, counts down to 1, and then the phase ends.

## Timing
- Start is sampled at edge k. `pulse_o` is high during cycles k+1 through k+H. The gap covers cycles k+H+1 through k+H+L, and so on for each pulse.
- The last pulse ends at cycle k+N·H+(N−1)·L. `done_o` is high in the following cycle and `busy_o` is low in that cycle.
- With N=0, `done_o`=1 in cycle k+1 and `pulse_o` never rises.
- Total train length is N·H+(N−1)·L cycles. There is one DONE cycle after the train, and IDLE accepts a new start on the edge after DONE.
- `busy_o` rises in cycle k+1 and falls in the DONE cycle. `busy_o`, `pulse_o` and `done_o` are all registered (state-decoded from registers), with no combinational path from any input.
- Reset asserted mid-train forces all outputs to 0 immediately (asynchronously) and returns the FSM to IDLE. No `done_o` is produced for the aborted train.

## Structure
- Shared package `pulsos_pkg` holds:
  - the state enum `gen_state_t` (IDLE, HIGH, LOW, DONE);
  - default width constants `GEN_CNT_W`=8 and `GEN_TIME_W`=16.
- One sub-module, `contador_fase`: a TIME_W-wide loadable down counter with `load_i`, `value_i` (applying the clamp to at least 1), and an `end_o` flag that is high in the final cycle of the phase. The FSM and the pulse counter stay in `gen_pulsos`.

## Test plan
- Reset then idle: `rst_i` pulsed mid-simulation, no start -> `pulse_o`, `busy_o` and `done_o` stay 0.
- Nominal train: N=3, high=4, low=2, start at edge k -> `pulse_o` high in cycles k+1..4, k+7..10 and k+13..16. `done_o` in cycle k+17 only. `busy_o` high in cycles k+1..16.
- Edge parameters: N=0 -> `done_o` at k+1 with no pulse. N=1, high=0, low=0 -> one 1-cycle pulse at k+1 and `done_o` at k+2.
- Ignored retrigger: `start_i` held high for the whole N=2, high=3, low=3 train, with the inputs changed mid-train -> exactly 2 pulses of 3 cycles. A new train starts on the edge after DONE.
- Reset mid-operation: `rst_i` asserted during the second HIGH of an N=4 train -> `pulse_o` is 0 in the same cycle, no `done_o`, and a fresh start afterwards produces a full 4-pulse train.
- Maximum values: N=255, high=1, low=1 -> 255 alternating pulses (509 cycles) and a single `done_o`, with no counter wrap.
